// File: rtl/prefix_operand_sequencer.sv
// Byte-serial operand sequencer for the 8-bit prefix adder: collects A then B, holds the pair
// until acknowledged, and counts issued pairs. Define PREFIX_CHAIN_EN to add sum chaining.
module prefix_operand_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       op_a,
   output logic [7:0]       op_b,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [CNT_W-1:0] pair_count
`ifdef PREFIX_CHAIN_EN
   ,
   input  logic [7:0]       sum_fb,
   input  logic             chain
`endif
);

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_OUT = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [7:0]       next_a;
   logic [7:0]       next_b;
   logic [CNT_W-1:0] next_count;
   logic             byte_take;
   logic             pair_take;

   // Handshake outputs come straight from the registered state, so neither
   // in_valid nor op_ready can reach them combinationally.
   assign in_ready = ((state == S_A) || (state == S_B)) && !rst;
   assign op_valid = (state == S_OUT);

   // Next-state and operand/counter update decode.
   always_comb begin
      next_state = state;
      next_a     = op_a;
      next_b     = op_b;
      next_count = pair_count;
      byte_take  = in_valid && in_ready;
      pair_take  = op_valid && op_ready;
      unique case (state)
         S_A: begin
            if (byte_take) begin
               next_a     = in_data;
               next_state = S_B;
            end
         end
         S_B: begin
            if (byte_take) begin
               next_b     = in_data;
               next_state = S_OUT;
            end
         end
         S_OUT: begin
            if (pair_take) begin
               next_count = pair_count + CNT_W'(1);
               next_state = S_A;
`ifdef PREFIX_CHAIN_EN
               // A chained sum becomes the next A, so only the B byte is still needed.
               if (chain) begin
                  next_a     = sum_fb;
                  next_state = S_B;
               end
`endif
            end
         end
         default: begin
            next_state = S_A;
         end
      endcase
   end

   // State, operand and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_A;
         op_a       <= 8'h00;
         op_b       <= 8'h00;
         pair_count <= '0;
      end else begin
         state      <= next_state;
         op_a       <= next_a;
         op_b       <= next_b;
         pair_count <= next_count;
      end
   end

endmodule

// File: tb/tb_prefix_operand_sequencer.sv
// Scoreboard bench for prefix_operand_sequencer: a byte-stream model pushes expected pairs,
// a monitor pops and checks them whenever op_valid is presented.
`timescale 1ns/1ps
module tb_prefix_operand_sequencer;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       op_a;
   logic [7:0]       op_b;
   logic             op_valid;
   logic             op_ready = 1'b0;
   logic [CNT_W-1:0] pair_count;
   logic [7:0]       adder_sum;
`ifdef PREFIX_CHAIN_EN
   logic [7:0]       sum_fb;
   logic             chain = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         idx;
      int         cyc;
   } pair_t;

   pair_t      q[$];
   bit         have_a = 1'b0;
   logic [7:0] cur_a = 8'h00;
   logic [7:0] last_a = 8'h00;
   logic [7:0] last_b = 8'h00;
   int         issued = 0;

   // Stand-in for the downstream combinational prefix adder.
   assign adder_sum = op_a + op_b;
`ifdef PREFIX_CHAIN_EN
   assign sum_fb = adder_sum;
`endif

   prefix_operand_sequencer #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .pair_count (pair_count)
`ifdef PREFIX_CHAIN_EN
      ,
      .sum_fb     (sum_fb),
      .chain      (chain)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic rs);
      in_valid = v;
      in_data  = d;
      op_ready = r;
      rst      = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] d);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("[TB] FAIL send_timeout: byte 0x%0h got no in_ready expected in_ready=1", d);
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      op_ready = 1'b1;
      for (int i = 0; i < 50 && q.size() > 0; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("drain_empty", q.size(), 0);
   endtask

   // Reference model: the accepted byte stream pairs up as A,B in order; a reset
   // discards everything pending and restarts the pair index; a chained handshake
   // turns the wrapped sum of the last pair into the next A.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            have_a = 1'b0;
            issued = 0;
         end else begin
`ifdef PREFIX_CHAIN_EN
            if (op_valid && op_ready && chain) begin
               cur_a  = last_a + last_b;
               have_a = 1'b1;
            end
`endif
            if (in_valid && in_ready) begin
               if (!have_a) begin
                  cur_a  = in_data;
                  have_a = 1'b1;
               end else begin
                  q.push_back('{a: cur_a, b: in_data, idx: issued, cyc: cyc});
                  last_a = cur_a;
                  last_b = in_data;
                  issued++;
                  have_a = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: compares every presented pair against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            checkOutput("rst_in_ready", in_ready, 0);
         end else if (op_valid) begin
            checkOutput("no_overlap_in_ready", in_ready, 0);
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_op_valid: got op_valid=1 expected 0");
            end else begin
               checkOutput("op_a", op_a, q[0].a);
               checkOutput("op_b", op_b, q[0].b);
               checkOutput("pair_count", pair_count, q[0].idx % (1 << CNT_W));
               checkOutput("adder_sum", adder_sum, (q[0].a + q[0].b) % 256);
               if (op_ready) void'(q.pop_front());
            end
         end else if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL op_valid_late: got op_valid=0 expected 1");
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_op_valid", op_valid, 0);
      checkOutput("reset_op_a", op_a, 0);
      checkOutput("reset_op_b", op_b, 0);
      checkOutput("reset_pair_count", pair_count, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

      // Mid-pair reset discards the pending A and the byte offered alongside it.
      sendByte(8'hAA);
      checkOutput("midrst_a_latched", op_a, 8'hAA);
      applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
      rst = 1'b0;
      checkOutput("midrst_op_a", op_a, 0);
      checkOutput("midrst_op_valid", op_valid, 0);
      checkOutput("midrst_pair_count", pair_count, 0);
      sendByte(8'h01);
      sendByte(8'h02);
      drain();
      checkOutput("midrst_fresh_count", pair_count, 1);

      // Basic back-to-back pair.
      op_ready = 1'b1;
      sendByte(8'h12);
      sendByte(8'h34);
      checkOutput("basic_sum", adder_sum, 8'h46);
      drain();
      checkOutput("basic_count", pair_count, 2);
      checkOutput("basic_valid_drop", op_valid, 0);

      // Backpressure: 0x77 waits with the producer until the pair is taken.
      op_ready = 1'b0;
      sendByte(8'h55);
      sendByte(8'h66);
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp_in_ready", in_ready, 0);
         checkOutput("bp_op_a", op_a, 8'h55);
         checkOutput("bp_op_b", op_b, 8'h66);
         @(posedge clk);
         #1;
      end
      op_ready = 1'b1;
      sendByte(8'h77);
      checkOutput("bp_next_a", op_a, 8'h77);
      sendByte(8'h88);
      drain();

      // Input gap between A and B.
      sendByte(8'hFF);
      repeat (3) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput("gap_op_valid", op_valid, 0);
         checkOutput("gap_op_a", op_a, 8'hFF);
      end
      sendByte(8'h01);
      checkOutput("gap_sum", adder_sum, 8'h00);
      drain();
      checkOutput("gap_count", pair_count, 5);

`ifdef PREFIX_CHAIN_EN
      // Chained pair: the sum 0x10 becomes the next A and only 0x05 is needed.
      chain = 1'b1;
      sendByte(8'hF0);
      sendByte(8'h20);
      drain();
      chain = 1'b0;
      sendByte(8'h05);
      checkOutput("chain_op_valid", op_valid, 1);
      checkOutput("chain_op_a", op_a, 8'h10);
      checkOutput("chain_op_b", op_b, 8'h05);
      drain();
      checkOutput("chain_count", pair_count, 7);
`endif

      // Full-rate stream, long enough to wrap the pair counter.
      for (int i = 0; i < 900; i++) begin
`ifdef PREFIX_CHAIN_EN
         chain = 1'($urandom_range(0, 1));
`endif
         applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
      end

      // Random valid/ready gaps with occasional resets.
      for (int i = 0; i < 2500; i++) begin
`ifdef PREFIX_CHAIN_EN
         chain = 1'($urandom_range(0, 1));
`endif
         applyStimulus(1'(($urandom % 4) != 0), 8'($urandom),
                       1'(($urandom % 3) != 0), 1'(($urandom % 200) == 0));
      end
`ifdef PREFIX_CHAIN_EN
      chain = 1'b0;
`endif
      rst = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
